// File: rtl/spi_regfile_pkg.sv
// -----------------------------------------------------------------------------
// spi_regfile_pkg
// Shared types and constants for the SPI register file slice.
//   state_e      : command FSM states
//   NREGS        : number of writable registers (addresses 0..NREGS-1)
//   ADDR_W       : register address width taken from the command byte
//   STATUS_ADDR  : read-only address that returns status_in
//   CMD_WR_BIT   : command byte bit that selects write (1) or read (0)
// -----------------------------------------------------------------------------
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'b00,
        STATE_WDATA   = 2'b01,
        STATE_DISCARD = 2'b10
    } state_e;

    localparam int              NREGS       = 7;
    localparam int              ADDR_W      = 3;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 3'd7;
    localparam int              CMD_WR_BIT  = 7;

    // True when the address maps onto a writable register.
    function automatic logic is_reg_addr(input logic [ADDR_W-1:0] addr);
        return (addr != STATUS_ADDR);
    endfunction

endpackage

// File: rtl/spi_regfile_if.sv
// -----------------------------------------------------------------------------
// spi_regfile_if
// Byte-level SPI slave side of the register file.
//   SSEL      : raw chip select, active low, asynchronous to clk
//   cmd       : received byte, qualified by cmd_valid
//   cmd_valid : one-cycle strobe per received byte
//   response  : byte the SPI slave shifts out in the next transaction
// master = SPI byte engine (or bench), slave = spi_regfile.
// -----------------------------------------------------------------------------
interface spi_regfile_if;
    logic       SSEL;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic [7:0] response;

    modport master (
        output SSEL,
        output cmd,
        output cmd_valid,
        input  response
    );

    modport slave (
        input  SSEL,
        input  cmd,
        input  cmd_valid,
        output response
    );
endinterface

// File: rtl/spi_regfile_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset, loads RST_VAL into both flops
//   d   : asynchronous input
//   q   : synchronized output
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/spi_regfile.sv
// -----------------------------------------------------------------------------
// spi_regfile
// Seven 8-bit registers plus a read-only status byte, accessed by SPI frames.
// A frame's first byte is a command (bit7 write/read, bits[2:0] address).
// A write takes the second byte as data; extra bytes are discarded. A read
// selects the byte returned in the following frame.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : spi_regfile_if.slave (SSEL, cmd, cmd_valid, response)
//   status_in : read-only status, returned when address 7 is selected
//   regs_out  : registers 0..6, reg n on bits [8n+7:8n]
//   wr_strobe : one-cycle pulse per committed write
//   wr_addr   : address of the last committed write
//   wr_data   : data of the last committed write
// -----------------------------------------------------------------------------
module spi_regfile
    import spi_regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    spi_regfile_if.slave         bus,
    input  logic [7:0]           status_in,
    output logic [NREGS*8-1:0]   regs_out,
    output logic                 wr_strobe,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [7:0]           wr_data
);

    localparam logic [1:0] ST_IDLE    = STATE_IDLE;
    localparam logic [1:0] ST_WDATA   = STATE_WDATA;
    localparam logic [1:0] ST_DISCARD = STATE_DISCARD;

    logic              ssel_s;
    logic              ssel_d_r;
    logic              frame_active_s;
    logic              frame_end_s;
    logic [1:0]        settle_r;
    logic              settle_done_s;
    logic              armed_r;
    logic              byte_ok_s;
    logic              is_write_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic [1:0]        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [7:0]        regs_r [NREGS];
    logic [7:0]        rd_data_s;
    logic [7:0]        response_r;
    logic              wr_strobe_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [7:0]        wr_data_r;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_ssel_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.SSEL),
        .q   (ssel_s)
    );

    // Previous synchronized chip select, for frame-end edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ssel_d_r <= 1'b1;
        end else begin
            ssel_d_r <= ssel_s;
        end
    end

    assign frame_active_s = ~ssel_s;
    assign frame_end_s    = ssel_s & ~ssel_d_r;

    // The synchronizer resets to "inactive", so its output is meaningless for
    // two cycles after reset; count them before trusting an idle SSEL.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_r <= 2'd0;
        end else if (settle_r != 2'd2) begin
            settle_r <= settle_r + 2'd1;
        end else begin
            settle_r <= settle_r;
        end
    end

    assign settle_done_s = (settle_r == 2'd2);

    // After reset, bytes are ignored until the bus is seen idle (either it
    // was idle at reset or the interrupted frame has ended). This keeps the
    // tail of a frame cut by reset from being parsed as a new command.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_r <= 1'b0;
        end else if (settle_done_s && ssel_s) begin
            armed_r <= 1'b1;
        end else begin
            armed_r <= armed_r;
        end
    end

    // A byte landing on the frame-end cycle still belongs to the frame.
    assign byte_ok_s  = bus.cmd_valid & (frame_active_s | frame_end_s) & armed_r;
    assign is_write_s = bus.cmd[CMD_WR_BIT];
    assign cmd_addr_s = bus.cmd[ADDR_W-1:0];

    // Command FSM, register array and write-report outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= 3'd0;
            rd_ptr_r    <= 3'd0;
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= 3'd0;
            wr_data_r   <= 8'h00;
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            wr_strobe_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (byte_ok_s) begin
                        if (is_write_s) begin
                            addr_r  <= cmd_addr_s;
                            state_r <= ST_WDATA;
                        end else begin
                            rd_ptr_r <= cmd_addr_s;
                            state_r  <= ST_DISCARD;
                        end
                    end
                end
                ST_WDATA: begin
                    if (byte_ok_s) begin
                        // The status address is read-only: drop the data silently.
                        if (is_reg_addr(addr_r)) begin
                            for (int i = 0; i < NREGS; i++) begin
                                if (addr_r == ADDR_W'(i)) begin
                                    regs_r[i] <= bus.cmd;
                                end
                            end
                            wr_strobe_r <= 1'b1;
                            wr_addr_r   <= addr_r;
                            wr_data_r   <= bus.cmd;
                        end
                        state_r <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    state_r <= ST_DISCARD;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            // Frame end wins over the transition above; the byte itself has
            // already been acted on in this same cycle.
            if (frame_end_s) begin
                state_r <= ST_IDLE;
            end
        end
    end

    // Read mux: registers by pointer, status at the top address.
    always_comb begin
        rd_data_s = status_in;
        case (rd_ptr_r)
            3'd0:    rd_data_s = regs_r[0];
            3'd1:    rd_data_s = regs_r[1];
            3'd2:    rd_data_s = regs_r[2];
            3'd3:    rd_data_s = regs_r[3];
            3'd4:    rd_data_s = regs_r[4];
            3'd5:    rd_data_s = regs_r[5];
            3'd6:    rd_data_s = regs_r[6];
            default: rd_data_s = status_in;
        endcase
    end

    // Response tracks the selected byte between frames and freezes while a
    // frame is active so the shifter sees a stable value.
    always_ff @(posedge clk) begin
        if (rst) begin
            response_r <= 8'h00;
        end else if (ssel_s) begin
            response_r <= rd_data_s;
        end else begin
            response_r <= response_r;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
        assign regs_out[g*8 +: 8] = regs_r[g];
    end

    assign bus.response = response_r;
    assign wr_strobe    = wr_strobe_r;
    assign wr_addr      = wr_addr_r;
    assign wr_data      = wr_data_r;

endmodule
